// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package key_debounce_pkg;

  localparam int unsigned DEBOUNCE_20MS_100MHZ = 2000000;
  localparam int unsigned STATE_W              = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  // Debounced level implied by a state: high once a press has been accepted.
  function automatic logic state_level(input state_e s);
    return (s == IDLE_HI) || (s == WAIT_LO);
  endfunction

  function automatic logic state_busy(input state_e s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; reset value selectable.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop sync, then a 4-state FSM with a stability counter.
// Build option KEY_DEBOUNCE_ACTIVE_LOW_EN: pin idles high (pull-up), pressed = 0.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_MAX = DEBOUNCE_20MS_100MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             key_q;
  logic             key_s;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             busy_d;

`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
  // Sync flops reset to the idle pin level so key_s reads "released" out of reset.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_q)
  );
  assign key_s = ~key_q;
`else
  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (key_q)
  );
  assign key_s = key_q;
`endif

  // State, counter and outputs; outputs load the decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE_LO;
      cnt_q     <= '0;
      key_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_level <= level_d;
      busy      <= busy_d;
    end
  end

  // Next state; a bounce is checked before completion so it wins on the last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE_LO: begin
        if (key_s) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!key_s)                 state_d = IDLE_LO;
        else if (cnt_q == CNT_LAST) state_d = IDLE_HI;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      IDLE_HI: begin
        if (!key_s) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (key_s)                  state_d = IDLE_HI;
        else if (cnt_q == CNT_LAST) state_d = IDLE_LO;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE_LO;
      end
    endcase
  end

  always_comb begin
    level_d = state_level(state_d);
    busy_d  = state_busy(state_d);
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a 8-cycle stability window.
module tb_key_debounce;

  localparam int unsigned CNT_MAX = 8;
  localparam int          LAT     = 2 + 1 + CNT_MAX;

  logic clk;
  logic rst_n;
  logic key_in;
  logic key_level;
  logic busy;

  int n_checks;
  int n_errors;

  logic [1:0] exp_q[$];
  string      tag_q[$];

  key_debounce #(.CNT_MAX(CNT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_level (key_level),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed/released to pin level for the active build option.
  function automatic logic pin(input logic pressed);
`ifdef KEY_DEBOUNCE_ACTIVE_LOW_EN
    return ~pressed;
`else
    return pressed;
`endif
  endfunction

  task automatic check(input string tag, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got {level,busy}=%b expected %b", tag, $time, act, exp);
    end
  endtask

  // One clock: drive the key, queue what must appear after the next edge, compare it.
  task automatic cycle(input logic pressed, input logic lvl, input logic bsy, input string tag);
    logic [1:0] e;
    string      t;
    key_in = pin(pressed);
    exp_q.push_back({lvl, bsy});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, {key_level, busy}, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, "reset_hold");
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, "reset_idle");
  endtask

  // Expected busy while the bounce test's short high runs start and abort.
  function automatic logic bounce_busy(input int j);
    return (j >= 2 && j <= 4) || (j >= 8 && j <= 10) || (j >= 14 && j <= LAT - 2 + 12);
  endfunction

  function automatic logic bounce_key(input int j);
    if (j < 12) return ((j / 3) % 2) == 0;
    return 1'b1;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    key_in   = pin(1'b1);

    // Reset held with the button pressed: outputs stay low.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, "reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "post_reset");

    // Clean press: busy from 3 edges after the step, level at edge 11.
    for (int j = 0; j < 14; j++)
      cycle(1'b1, j >= LAT - 1, (j >= 2) && (j <= LAT - 2), "clean_press");

    // Clean release mirrors the press.
    for (int j = 0; j < 13; j++)
      cycle(1'b0, j < LAT - 1, (j >= 2) && (j <= LAT - 2), "clean_release");

    do_reset();

    // Bounce: 3-cycle runs abort the wait; level only after the final rising step.
    for (int j = 0; j < 26; j++)
      cycle(bounce_key(j), j >= 12 + LAT - 1, bounce_busy(j), "bounce_press");

    do_reset();

    // Glitch arrives exactly on the final count: abort wins, back to idle-low.
    for (int j = 0; j < 16; j++)
      cycle(j < CNT_MAX, 1'b0, (j >= 2) && (j <= LAT - 2), "late_glitch");

    // Fresh press afterwards still needs the full window.
    for (int j = 0; j < 13; j++)
      cycle(1'b1, j >= LAT - 1, (j >= 2) && (j <= LAT - 2), "press_after_glitch");

    // Release, then reset mid-wait at count 4: level drops immediately.
    for (int j = 0; j < 7; j++)
      cycle(1'b0, 1'b1, j >= 2, "release_wait");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {key_level, busy}, 2'b00);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, "async_reset_hold");
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) cycle(1'b0, 1'b0, 1'b0, "after_reset_idle");
    for (int j = 0; j < 13; j++)
      cycle(1'b1, j >= LAT - 1, (j >= 2) && (j <= LAT - 2), "press_after_reset");

    check("scoreboard_drained", 2'(exp_q.size()), 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
